// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux_reg block: select-mode encodings and
// the ceiling-log2 helper used to size the select/tag field.
package scan_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Smallest r with 2**r >= n; used only at elaboration time.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_mux_reg_rr_next_sel.sv
// Round-robin channel finder: first set bit of mask_i at or after ptr_i,
// searching circularly. The mask is doubled and rotated right by ptr_i, so
// the first set bit of the rotated vector is the wanted channel's distance
// from ptr_i.
module rr_next_sel
   import scan_mux_pkg::*;
#(
   parameter int NCH  = 8,
   parameter int SELW = clog2(NCH)
) (
   input  logic [NCH-1:0]  mask_i,
   input  logic [SELW-1:0] ptr_i,
   output logic            found_o,
   output logic [SELW-1:0] idx_o,
   output logic            last_o
);

   logic [2*NCH-1:0] dbl;
   int               off;
   int               c;

   // Rotate, priority-encode, then decide whether c ends the sweep.
   // NOTE: combinational blocks use blocking '=' so later statements see the
   // values just computed; every output gets a default first so no latch forms.
   always_comb begin
      dbl     = {mask_i, mask_i} >> ptr_i;
      off     = 0;
      for (int i = 2*NCH-1; i >= 0; i--) begin
         if (dbl[i]) off = i;
      end
      c = int'(ptr_i) + off;
      if (c >= NCH) c = c - NCH;
      last_o = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (mask_i[i] && (i > c)) last_o = 1'b0;
      end
      found_o = |mask_i;
      idx_o   = SELW'(c);
   end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel mux with manual (151-style) or round-robin scan
// selection, presenting each captured sample as a valid/ready beat tagged
// with its channel index.
module scan_mux_reg
   import scan_mux_pkg::*;
#(
   parameter int NCH  = 8,
   parameter int WID  = 1,
   parameter int SELW = clog2(NCH)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               e_n,
   input  logic               mode_i,
   input  logic [SELW-1:0]    sel_i,
   input  logic [NCH-1:0]     mask_i,
   input  logic [NCH*WID-1:0] din_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [WID-1:0]     z_o,
   output logic [WID-1:0]     z_n_o,
   output logic [SELW-1:0]    ch_o,
   output logic               wrap_o
);

   logic            valid_q, valid_d;
   logic [WID-1:0]  z_q, z_d;
   logic [WID-1:0]  z_n_q, z_n_d;
   logic [SELW-1:0] ch_q, ch_d;
   logic            wrap_q, wrap_d;
   logic [SELW-1:0] ptr_q, ptr_d;

   logic            rr_found;
   logic [SELW-1:0] rr_idx;
   logic            rr_last;
   logic [SELW-1:0] ptr_nxt;
   logic [SELW-1:0] sel_idx;
   logic [WID-1:0]  mux_data;
   logic            have_ch;
   logic            cap;

   rr_next_sel #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_rr (
      .mask_i  (mask_i),
      .ptr_i   (ptr_q),
      .found_o (rr_found),
      .idx_o   (rr_idx),
      .last_o  (rr_last)
   );

   // Pick the channel for this cycle and fetch its data; an index beyond the
   // last channel (non-power-of-two NCH) reads as zero.
   always_comb begin
      sel_idx  = (mode_i == MODE_SCAN) ? rr_idx : sel_i;
      mux_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (int'(sel_idx) == k) mux_data = din_i[k*WID +: WID];
      end
      ptr_nxt = (int'(rr_idx) == NCH-1) ? '0 : rr_idx + SELW'(1);
      have_ch = (mode_i == MODE_SCAN) ? rr_found : 1'b1;
      cap     = !e_n && (!valid_q || ready_i) && have_ch;
   end

   // Next-state for the beat register: capture, drain, or hold.
   always_comb begin
      valid_d = valid_q;
      z_d     = z_q;
      z_n_d   = z_n_q;
      ch_d    = ch_q;
      wrap_d  = wrap_q;
      ptr_d   = ptr_q;
      if (cap) begin
         valid_d = 1'b1;
         z_d     = mux_data;
         z_n_d   = ~mux_data;
         ch_d    = sel_idx;
         if (mode_i == MODE_SCAN) begin
            wrap_d = rr_last;
            ptr_d  = ptr_nxt;
         end else begin
            wrap_d = 1'b0;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Beat and scan-pointer registers.
   // NOTE: reset is sampled on the clock edge (synchronous), so rst_i is not
   // in the sensitivity list; state updates use non-blocking '<='.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         z_q     <= '0;
         z_n_q   <= '1;
         ch_q    <= '0;
         wrap_q  <= 1'b0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         z_q     <= z_d;
         z_n_q   <= z_n_d;
         ch_q    <= ch_d;
         wrap_q  <= wrap_d;
         ptr_q   <= ptr_d;
      end
   end

   assign valid_o = valid_q;
   assign z_o     = z_q;
   assign z_n_o   = z_n_q;
   assign ch_o    = ch_q;
   assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Scoreboard bench for scan_mux_reg: one instance at NCH=8/WID=8 and one at
// NCH=5/WID=4. Tasks push expected beats; negedge monitors compare the
// presented beat and pop it when it is accepted.
module tb_scan_mux_reg;

   localparam int NA = 8;
   localparam int WA = 8;
   localparam int SA = 3;
   localparam int NB = 5;
   localparam int WB = 4;
   localparam int SB = 3;

   typedef struct {
      logic [31:0] ch;
      logic [31:0] z;
      logic        wrap;
   } beat_t;

   beat_t q_a[$];
   beat_t q_b[$];
   int    checks = 0;
   int    errors = 0;

   logic clk = 1'b0;
   logic rst;

   logic          e_n_a, mode_a, ready_a;
   logic [SA-1:0] sel_a;
   logic [NA-1:0] mask_a;
   logic [NA*WA-1:0] din_a;
   logic          valid_a, wrap_a;
   logic [WA-1:0] z_a, z_n_a;
   logic [SA-1:0] ch_a;

   logic          e_n_b, mode_b, ready_b;
   logic [SB-1:0] sel_b;
   logic [NB-1:0] mask_b;
   logic [NB*WB-1:0] din_b;
   logic          valid_b, wrap_b;
   logic [WB-1:0] z_b, z_n_b;
   logic [SB-1:0] ch_b;

   always #5 clk = ~clk;

   scan_mux_reg #(.NCH(NA), .WID(WA)) dut_a (
      .clk_i(clk), .rst_i(rst), .e_n(e_n_a), .mode_i(mode_a), .sel_i(sel_a),
      .mask_i(mask_a), .din_i(din_a), .ready_i(ready_a), .valid_o(valid_a),
      .z_o(z_a), .z_n_o(z_n_a), .ch_o(ch_a), .wrap_o(wrap_a)
   );

   scan_mux_reg #(.NCH(NB), .WID(WB)) dut_b (
      .clk_i(clk), .rst_i(rst), .e_n(e_n_b), .mode_i(mode_b), .sel_i(sel_b),
      .mask_i(mask_b), .din_i(din_b), .ready_i(ready_b), .valid_o(valid_b),
      .z_o(z_b), .z_n_o(z_n_b), .ch_o(ch_b), .wrap_o(wrap_b)
   );

   function automatic beat_t mk(input int ch, input int z, input logic wrap);
      beat_t b;
      b.ch   = 32'(ch);
      b.z    = 32'(z);
      b.wrap = wrap;
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_din_a(input logic [7:0] flip);
      for (int k = 0; k < NA; k++) din_a[k*WA +: WA] = (8'h10 + 8'(k)) ^ flip;
   endtask

   // Monitor for instance A: compare the presented beat, pop on acceptance.
   always @(negedge clk) begin
      beat_t e;
      if (!rst && valid_a) begin
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL a_beat unexpected: ch=%0d z=%h", ch_a, z_a);
         end else begin
            e = q_a[0];
            if (32'(ch_a) !== e.ch || 32'(z_a) !== e.z || z_n_a !== ~e.z[WA-1:0] || wrap_a !== e.wrap) begin
               errors++;
               $display("FAIL a_beat got ch=%0d z=%h zn=%h wrap=%b, want ch=%0d z=%h zn=%h wrap=%b",
                        ch_a, z_a, z_n_a, wrap_a, e.ch, e.z[WA-1:0], ~e.z[WA-1:0], e.wrap);
            end
            if (ready_a) void'(q_a.pop_front());
         end
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      beat_t e;
      if (!rst && valid_b) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL b_beat unexpected: ch=%0d z=%h", ch_b, z_b);
         end else begin
            e = q_b[0];
            if (32'(ch_b) !== e.ch || 32'(z_b) !== e.z || z_n_b !== ~e.z[WB-1:0] || wrap_b !== e.wrap) begin
               errors++;
               $display("FAIL b_beat got ch=%0d z=%h zn=%h wrap=%b, want ch=%0d z=%h zn=%h wrap=%b",
                        ch_b, z_b, z_n_b, wrap_b, e.ch, e.z[WB-1:0], ~e.z[WB-1:0], e.wrap);
            end
            if (ready_b) void'(q_b.pop_front());
         end
      end
   end

   task automatic expect_idle_a(input string name);
      checks++;
      if (valid_a !== 1'b0) begin
         errors++;
         $display("FAIL %s valid_a=%b want 0", name, valid_a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (valid_a !== 1'b0 || z_a !== 8'h00 || z_n_a !== 8'hFF || ch_a !== 3'd0 || wrap_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_a got v=%b z=%h zn=%h ch=%0d w=%b want 0 00 ff 0 0", valid_a, z_a, z_n_a, ch_a, wrap_a);
      end
      checks++;
      if (valid_b !== 1'b0 || z_b !== 4'h0 || z_n_b !== 4'hF || ch_b !== 3'd0 || wrap_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_b got v=%b z=%h zn=%h ch=%0d w=%b want 0 0 f 0 0", valid_b, z_b, z_n_b, ch_b, wrap_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_manual();
      mode_a = 1'b0; sel_a = 3'd5; ready_a = 1'b1; e_n_a = 1'b0;
      q_a.push_back(mk(5, 'h15, 1'b0));
      step();
      checks++;
      if (valid_a !== 1'b1) begin
         errors++;
         $display("FAIL manual_latency valid_a=%b want 1", valid_a);
      end
      sel_a = 3'd2;
      q_a.push_back(mk(2, 'h12, 1'b0));
      step();
      e_n_a = 1'b1;
      step();
      expect_idle_a("manual_drain");
   endtask

   task automatic test_scan();
      mode_a = 1'b1; mask_a = 8'b1010_0101; ready_a = 1'b1; e_n_a = 1'b0;
      q_a.push_back(mk(0, 'h10, 1'b0));
      q_a.push_back(mk(2, 'h12, 1'b0));
      q_a.push_back(mk(5, 'h15, 1'b0));
      q_a.push_back(mk(7, 'h17, 1'b1));
      q_a.push_back(mk(0, 'h10, 1'b0));
      q_a.push_back(mk(2, 'h12, 1'b0));
      repeat (6) step();
      e_n_a = 1'b1;
      step();
      expect_idle_a("scan_drain");
   endtask

   task automatic test_back_to_back_backpressure();
      e_n_a = 1'b0; ready_a = 1'b1;
      q_a.push_back(mk(5, 'h15, 1'b0));
      step();
      ready_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_din_a(8'(8'hA5 + i));
         step();
      end
      set_din_a(8'h00);
      ready_a = 1'b1;
      q_a.push_back(mk(7, 'h17, 1'b1));
      q_a.push_back(mk(0, 'h10, 1'b0));
      q_a.push_back(mk(2, 'h12, 1'b0));
      repeat (3) step();
      e_n_a = 1'b1;
      step();
      expect_idle_a("backpressure_drain");
   endtask

   task automatic test_mask_edit();
      mask_a = 8'b0000_0011; e_n_a = 1'b0; ready_a = 1'b1;
      q_a.push_back(mk(0, 'h10, 1'b0));
      q_a.push_back(mk(1, 'h11, 1'b1));
      repeat (2) step();
      mask_a = 8'b0000_0000;
      step();
      expect_idle_a("mask_zero_drain");
      step();
      expect_idle_a("mask_zero_stays_idle");
   endtask

   task automatic test_enable();
      mask_a = 8'b1010_0101; e_n_a = 1'b0; ready_a = 1'b0;
      q_a.push_back(mk(2, 'h12, 1'b0));
      step();
      e_n_a = 1'b1;
      repeat (2) step();
      checks++;
      if (valid_a !== 1'b1) begin
         errors++;
         $display("FAIL enable_hold valid_a=%b want 1", valid_a);
      end
      ready_a = 1'b1;
      step();
      expect_idle_a("enable_accept");
      step();
      expect_idle_a("enable_no_new_beat");
   endtask

   task automatic test_reset_mid();
      e_n_a = 1'b0; ready_a = 1'b1;
      q_a.push_back(mk(5, 'h15, 1'b0));
      step();
      ready_a = 1'b0;
      rst = 1'b1;
      step();
      if (q_a.size() > 0) void'(q_a.pop_front());
      checks++;
      if (valid_a !== 1'b0 || z_a !== 8'h00 || z_n_a !== 8'hFF || ch_a !== 3'd0 || wrap_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got v=%b z=%h zn=%h ch=%0d w=%b want 0 00 ff 0 0", valid_a, z_a, z_n_a, ch_a, wrap_a);
      end
      rst = 1'b0; ready_a = 1'b1;
      q_a.push_back(mk(0, 'h10, 1'b0));
      q_a.push_back(mk(2, 'h12, 1'b0));
      repeat (2) step();
      e_n_a = 1'b1;
      step();
      expect_idle_a("reset_mid_drain");
   endtask

   task automatic test_non_pow2();
      mode_b = 1'b0; sel_b = 3'd6; e_n_b = 1'b0; ready_b = 1'b1;
      q_b.push_back(mk(6, 0, 1'b0));
      step();
      checks++;
      if (valid_b !== 1'b1) begin
         errors++;
         $display("FAIL np2_oob_valid valid_b=%b want 1", valid_b);
      end
      sel_b = 3'd4;
      q_b.push_back(mk(4, 5, 1'b0));
      step();
      mode_b = 1'b1; mask_b = 5'b11111;
      for (int k = 0; k < NB; k++) q_b.push_back(mk(k, k + 1, k == NB - 1));
      q_b.push_back(mk(0, 1, 1'b0));
      repeat (6) step();
      e_n_b = 1'b1;
      step();
      checks++;
      if (valid_b !== 1'b0) begin
         errors++;
         $display("FAIL np2_drain valid_b=%b want 0", valid_b);
      end
   endtask

   initial begin
      rst = 1'b1;
      e_n_a = 1'b1; mode_a = 1'b0; sel_a = '0; mask_a = '0; ready_a = 1'b0;
      e_n_b = 1'b1; mode_b = 1'b0; sel_b = '0; mask_b = '0; ready_b = 1'b0;
      set_din_a(8'h00);
      for (int k = 0; k < NB; k++) din_b[k*WB +: WB] = 4'(k + 1);

      test_reset();
      test_manual();
      test_scan();
      test_back_to_back_backpressure();
      test_mask_edit();
      test_enable();
      test_reset_mid();
      test_non_pow2();

      checks++;
      if (q_a.size() != 0) begin
         errors++;
         $display("FAIL a_leftover %0d beats never seen, want 0", q_a.size());
      end
      checks++;
      if (q_b.size() != 0) begin
         errors++;
         $display("FAIL b_leftover %0d beats never seen, want 0", q_b.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
